// File: rtl/page_cmd_queue_pkg.sv
// Shared types and constants for the page command queue: opcodes, param layout, queue word.
package page_cmd_queue_pkg;

    localparam int unsigned CREDIT_W = 4;
    localparam int unsigned QWORD_W  = 113;

    localparam logic [15:0] NFC_CMD_READ = 16'h3000;

    typedef struct packed {
        logic [15:0] len;
        logic [11:0] col;
        logic [2:0]  mode;
        logic        en;
    } page_param_t;

    typedef struct packed {
        logic [15:0] cmd;
        logic        last;
        logic [15:0] id;
        logic [47:0] addr;
        page_param_t param;
    } page_cmd_t;

    function automatic logic is_read(input logic [15:0] cmd);
        return cmd == NFC_CMD_READ;
    endfunction

endpackage

// File: rtl/nfc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word and occupancy count.
module nfc_sync_fifo #(
    parameter int unsigned WIDTH = 113,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    count_next;

    always_comb begin
        rd_ptr_inc = rd_ptr + AW'(1);
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head register: next stored entry on pop, or the incoming word when the queue drains into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count <= count_next;
            valid <= (count_next != '0);
            if (pop && (count > CW'(1))) begin
                dout <= mem[rd_ptr_inc];
            end else if (push && ((count == '0) || pop)) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/page_cmd_queue.sv
// Page command queue between page schedulers and the NFC command port.
// Optional protocol checking is enabled by defining NFC_QUEUE_CHECK_EN.
module page_cmd_queue
    import page_cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BUF_PAGES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_page_cmd_valid,
    input  logic [15:0]               i_page_cmd,
    input  logic                      i_page_cmd_last,
    input  logic [15:0]               i_page_cmd_id,
    input  logic [47:0]               i_page_addr,
    input  logic [31:0]               i_page_cmd_param,
    output logic                      o_page_cmd_ready,
    output logic                      o_page_buf_ready,
    output logic                      o_nfc_valid,
    input  logic                      i_nfc_ready,
    output logic [15:0]               o_nfc_cmd,
    output logic                      o_nfc_last,
    output logic [15:0]               o_nfc_id,
    output logic [47:0]               o_nfc_addr,
    output logic [31:0]               o_nfc_param,
    input  logic                      i_buf_release,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_err
);

    localparam int unsigned         LVL_W      = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0]    LVL_FULL   = LVL_W'(DEPTH);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(BUF_PAGES);

    page_cmd_t           in_word;
    page_cmd_t           head_word;
    logic                push;
    logic                pop;
    logic                rel;
    logic                dec;
    logic                full;
    logic [LVL_W-1:0]    level_next;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_next;
`ifdef NFC_QUEUE_CHECK_EN
    logic                overflow_err;
    logic                credit_err;
    logic                release_err;
`endif

    assign in_word = {i_page_cmd, i_page_cmd_last, i_page_cmd_id, i_page_addr, i_page_cmd_param};

    // Accept/drop decisions for push and release, then next credit and level.
    always_comb begin
        pop  = o_nfc_valid && i_nfc_ready;
        full = (o_level == LVL_FULL);
`ifdef NFC_QUEUE_CHECK_EN
        overflow_err = i_page_cmd_valid && full && !pop;
        credit_err   = i_page_cmd_valid && in_word.param.en && (credit == '0);
        release_err  = i_buf_release && (credit == CREDIT_MAX);
        push         = i_page_cmd_valid && !overflow_err && !credit_err;
        rel          = i_buf_release && !release_err;
`else
        push = i_page_cmd_valid && !(full && !pop);
        rel  = i_buf_release;
`endif
        dec         = push && in_word.param.en;
        credit_next = credit;
        if (dec && !rel && (credit != '0)) begin
            credit_next = credit - CREDIT_W'(1);
        end else if (rel && !dec && (credit != CREDIT_MAX)) begin
            credit_next = credit + CREDIT_W'(1);
        end
        level_next = o_level + LVL_W'(push) - LVL_W'(pop);
    end

    // Ready drops for the cycle after every capture so the producer sees a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit           <= CREDIT_MAX;
            o_page_cmd_ready <= 1'b1;
            o_page_buf_ready <= 1'b1;
        end else begin
            credit           <= credit_next;
            o_page_cmd_ready <= !i_page_cmd_valid && (level_next < LVL_FULL);
            o_page_buf_ready <= (credit_next != '0);
        end
    end

`ifdef NFC_QUEUE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (overflow_err || credit_err || release_err) begin
            o_err <= 1'b1;
        end
    end
`else
    assign o_err = 1'b0;
`endif

    nfc_sync_fifo #(
        .WIDTH (QWORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_word),
        .dout  (head_word),
        .valid (o_nfc_valid),
        .count (o_level)
    );

    assign o_nfc_cmd   = head_word.cmd;
    assign o_nfc_last  = head_word.last;
    assign o_nfc_id    = head_word.id;
    assign o_nfc_addr  = head_word.addr;
    assign o_nfc_param = head_word.param;

endmodule

// File: tb/tb_page_cmd_queue.sv
// Self-checking bench for page_cmd_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_page_cmd_queue;
    import page_cmd_queue_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned BUF_PAGES = 4;
`ifdef NFC_QUEUE_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_page_cmd_valid = 1'b0;
    logic [15:0] i_page_cmd = '0;
    logic        i_page_cmd_last = 1'b0;
    logic [15:0] i_page_cmd_id = '0;
    logic [47:0] i_page_addr = '0;
    logic [31:0] i_page_cmd_param = '0;
    logic        i_nfc_ready = 1'b0;
    logic        i_buf_release = 1'b0;
    logic        o_page_cmd_ready;
    logic        o_page_buf_ready;
    logic        o_nfc_valid;
    logic [15:0] o_nfc_cmd;
    logic        o_nfc_last;
    logic [15:0] o_nfc_id;
    logic [47:0] o_nfc_addr;
    logic [31:0] o_nfc_param;
    logic [2:0]  o_level;
    logic        o_err;

    page_cmd_queue #(.DEPTH(DEPTH), .BUF_PAGES(BUF_PAGES)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_page_cmd_valid (i_page_cmd_valid),
        .i_page_cmd       (i_page_cmd),
        .i_page_cmd_last  (i_page_cmd_last),
        .i_page_cmd_id    (i_page_cmd_id),
        .i_page_addr      (i_page_addr),
        .i_page_cmd_param (i_page_cmd_param),
        .o_page_cmd_ready (o_page_cmd_ready),
        .o_page_buf_ready (o_page_buf_ready),
        .o_nfc_valid      (o_nfc_valid),
        .i_nfc_ready      (i_nfc_ready),
        .o_nfc_cmd        (o_nfc_cmd),
        .o_nfc_last       (o_nfc_last),
        .o_nfc_id         (o_nfc_id),
        .o_nfc_addr       (o_nfc_addr),
        .o_nfc_param      (o_nfc_param),
        .i_buf_release    (i_buf_release),
        .o_level          (o_level),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of commands plus an integer credit count.
    page_cmd_t m_q[$];
    int        m_credit = BUF_PAGES;
    bit        m_err = 1'b0;
    bit        m_ready = 1'b1;
    bit        m_buf_ready = 1'b1;

    always @(posedge clk) begin
        page_cmd_t w;
        bit pop, push, rel, en;
        w  = {i_page_cmd, i_page_cmd_last, i_page_cmd_id, i_page_addr, i_page_cmd_param};
        en = i_page_cmd_param[0];
        if (rst) begin
            m_q.delete();
            m_credit    = BUF_PAGES;
            m_err       = 1'b0;
            m_ready     = 1'b1;
            m_buf_ready = 1'b1;
        end else begin
            pop  = (m_q.size() != 0) && i_nfc_ready;
            push = i_page_cmd_valid && !((m_q.size() == DEPTH) && !pop);
            if (CHECK && i_page_cmd_valid && !push) m_err = 1'b1;
            if (CHECK && i_page_cmd_valid && en && (m_credit == 0)) begin
                push  = 1'b0;
                m_err = 1'b1;
            end
            rel = i_buf_release;
            if (CHECK && rel && (m_credit == int'(BUF_PAGES))) begin
                rel   = 1'b0;
                m_err = 1'b1;
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(w);
            m_credit = m_credit - ((push && en) ? 1 : 0) + (rel ? 1 : 0);
            if (m_credit < 0) m_credit = 0;
            if (m_credit > int'(BUF_PAGES)) m_credit = int'(BUF_PAGES);
            m_ready     = !i_page_cmd_valid && (m_q.size() < DEPTH);
            m_buf_ready = (m_credit != 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("level", 64'(o_level), 64'(m_q.size()));
            chk("nfc_valid", 64'(o_nfc_valid), 64'(m_q.size() != 0));
            chk("cmd_ready", 64'(o_page_cmd_ready), 64'(m_ready));
            chk("buf_ready", 64'(o_page_buf_ready), 64'(m_buf_ready));
            chk("err", 64'(o_err), 64'(m_err));
            if (m_q.size() != 0) begin
                chk("head_cmd", 64'(o_nfc_cmd), 64'(m_q[0].cmd));
                chk("head_last", 64'(o_nfc_last), 64'(m_q[0].last));
                chk("head_id", 64'(o_nfc_id), 64'(m_q[0].id));
                chk("head_addr", 64'(o_nfc_addr), 64'(m_q[0].addr));
                chk("head_param", 64'(o_nfc_param), 64'(m_q[0].param));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] cmd, input logic last, input logic [15:0] id,
                        input logic [47:0] addr, input logic [31:0] param);
        i_page_cmd_valid = 1'b1;
        i_page_cmd       = cmd;
        i_page_cmd_last  = last;
        i_page_cmd_id    = id;
        i_page_addr      = addr;
        i_page_cmd_param = param;
        tick();
        i_page_cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        started = 1'b1;
        chk("rst_cmd_ready", 64'(o_page_cmd_ready), 64'd1);
        chk("rst_buf_ready", 64'(o_page_buf_ready), 64'd1);
        chk("rst_nfc_valid", 64'(o_nfc_valid), 64'd0);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_nfc_cmd", 64'(o_nfc_cmd), 64'd0);
        chk("rst_nfc_addr", 64'(o_nfc_addr), 64'd0);
        chk("rst_nfc_param", 64'(o_nfc_param), 64'd0);

        // Single read
        send(NFC_CMD_READ, 1'b1, 16'h0001, 48'h0001_0000, 32'h2000_8007);
        chk("rd_cmd_ready", 64'(o_page_cmd_ready), 64'd0);
        chk("rd_nfc_valid", 64'(o_nfc_valid), 64'd1);
        chk("rd_nfc_cmd", 64'(o_nfc_cmd), 64'h3000);
        chk("rd_nfc_addr", 64'(o_nfc_addr), 64'h0001_0000);
        chk("rd_nfc_param", 64'(o_nfc_param), 64'h2000_8007);
        chk("rd_level1", 64'(o_level), 64'd1);
        i_nfc_ready = 1'b1;
        tick();
        chk("rd_level0", 64'(o_level), 64'd0);
        chk("rd_ready_back", 64'(o_page_cmd_ready), 64'd1);
        i_nfc_ready = 1'b0;

        // Back-to-back fill under backpressure, then ordered drain
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(16'h8010, 1'b0, 16'(i), 48'(i * 16), 32'h0010_0000);
            tick();
        end
        chk("fill_level", 64'(o_level), 64'd4);
        chk("fill_ready_low", 64'(o_page_cmd_ready), 64'd0);
        chk("fill_id1", 64'(o_nfc_id), 64'd1);
        i_nfc_ready = 1'b1;
        tick();
        chk("fill_ready_after_pop", 64'(o_page_cmd_ready), 64'd1);
        chk("fill_id2", 64'(o_nfc_id), 64'd2);
        tick();
        chk("fill_id3", 64'(o_nfc_id), 64'd3);
        tick();
        chk("fill_id4", 64'(o_nfc_id), 64'd4);
        tick();
        chk("fill_empty", 64'(o_level), 64'd0);
        i_nfc_ready = 1'b0;

        // Credit exhaustion and recovery
        do_reset();
        i_nfc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(NFC_CMD_READ, 1'b0, 16'(10 + i), 48'h0, 32'h0001_0001);
            tick();
        end
        chk("cred_exhausted", 64'(o_page_buf_ready), 64'd0);
        i_buf_release = 1'b1;
        tick();
        chk("cred_release", 64'(o_page_buf_ready), 64'd1);
        send(NFC_CMD_READ, 1'b0, 16'd20, 48'h0, 32'h0001_0001);
        i_buf_release = 1'b0;
        chk("cred_coincident", 64'(o_page_buf_ready), 64'd1);
        tick();
        send(NFC_CMD_READ, 1'b0, 16'd21, 48'h0, 32'h0001_0001);
        chk("cred_last_used", 64'(o_page_buf_ready), 64'd0);
        tick();

        // Backpressure stability, push+pop at full, forced overflow
        do_reset();
        i_nfc_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(16'h00E0 + 16'(i), 1'(i & 1), 16'(i), 48'hABCD_0000_0000 + 48'(i), 32'h0100_0000);
            tick();
        end
        repeat (10) begin
            tick();
            chk("stable_id", 64'(o_nfc_id), 64'd1);
            chk("stable_addr", 64'(o_nfc_addr), 64'hABCD_0000_0001);
        end
        i_nfc_ready = 1'b1;
        send(16'h00E5, 1'b0, 16'd5, 48'h5, 32'h0100_0000);
        i_nfc_ready = 1'b0;
        chk("pushpop_level", 64'(o_level), 64'd4);
        chk("pushpop_err", 64'(o_err), 64'd0);
        chk("pushpop_id", 64'(o_nfc_id), 64'd2);
        send(16'h00E6, 1'b0, 16'd6, 48'h6, 32'h0100_0000);
        chk("ovf_level", 64'(o_level), 64'd4);
        chk("ovf_err", 64'(o_err), 64'(CHECK));
        do_reset();
        i_buf_release = 1'b1;
        tick();
        i_buf_release = 1'b0;
        chk("rel_full_err", 64'(o_err), 64'(CHECK));
        tick();

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(NFC_CMD_READ, 1'b0, 16'(30 + i), 48'h0, 32'h0001_0001);
            tick();
        end
        chk("mid_level3", 64'(o_level), 64'd3);
        do_reset();
        chk("mid_level0", 64'(o_level), 64'd0);
        chk("mid_nfc_valid", 64'(o_nfc_valid), 64'd0);
        chk("mid_cmd_ready", 64'(o_page_cmd_ready), 64'd1);
        chk("mid_buf_ready", 64'(o_page_buf_ready), 64'd1);
        i_nfc_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(NFC_CMD_READ, 1'b0, 16'(40 + i), 48'h0, 32'h0001_0001);
            tick();
        end
        chk("mid_credit_restored", 64'(o_page_buf_ready), 64'd1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst              = ($urandom_range(0, 499) == 0);
            i_page_cmd_valid = m_ready && ($urandom_range(0, 2) == 0);
            i_page_cmd       = 16'($urandom);
            i_page_cmd_last  = 1'($urandom);
            i_page_cmd_id    = 16'($urandom);
            i_page_addr      = {16'($urandom), 32'($urandom)};
            i_page_cmd_param = 32'($urandom);
            i_nfc_ready      = ($urandom_range(0, 3) != 0);
            i_buf_release    = (m_credit < int'(BUF_PAGES)) && ($urandom_range(0, 3) == 0);
            tick();
        end
        rst              = 1'b0;
        i_page_cmd_valid = 1'b0;
        i_buf_release    = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
